// File: rtl/uart_sim_pkg.sv
// Shared UART simulation package: line-control characters, byte width and
// the line-feed FSM state type. Also used by the UART print monitor.
package uart_sim_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_CR   = 3'd2,
        ST_LF   = 3'd3,
        ST_GAP  = 3'd4
    } line_state_e;

    // True for either end-of-line character
    function automatic logic is_eol(input logic [BYTE_W-1:0] c);
        return (c == CHAR_CR) || (c == CHAR_LF);
    endfunction

endpackage

// File: rtl/uart_line_buf.sv
// Line buffer: DEPTH x 8 storage, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module uart_line_buf
    import uart_sim_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read port
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_line_feed.sv
// Line-oriented UART feeder. Characters are collected into a line buffer;
// on a send request (send pulse, or a written CR/LF) the line is streamed
// out as a valid/ready byte stream, optionally followed by CR LF, with a
// fixed idle gap after every accepted byte.
//   clk             : clock
//   resetn          : asynchronous active-low reset
//   wr_data/valid   : character write request
//   wr_ready        : write accepted when valid & ready
//   send            : single-cycle request to transmit the buffered line
//   uart_data/valid : output byte stream
//   uart_data_ready : sink accepts byte when valid & ready
//   busy            : transmission in progress (state != IDLE)
//   count           : number of buffered bytes
module uart_line_feed
    import uart_sim_pkg::*;
#(
    parameter int unsigned CHARLEN  = 256,
    parameter int unsigned GAP      = 2,
    parameter int unsigned AUTO_EOL = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [7:0]                wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      send,
    output logic [7:0]                uart_data,
    output logic                      uart_data_valid,
    input  logic                      uart_data_ready,
    output logic                      busy,
    output logic [$clog2(CHARLEN):0]  count
);

    localparam int unsigned CNT_W = $clog2(CHARLEN) + 1;
    localparam int unsigned AW    = (CHARLEN > 1) ? $clog2(CHARLEN) : 1;
    localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;

    line_state_e       state_q, state_d;
    line_state_e       nxt_q, nxt_d;
    line_state_e       after_st;
    line_state_e       tgt;
    logic              enter;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]  rd_idx_inc;
    logic [GW-1:0]     gap_q, gap_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q;
    logic              wr_ready_q;

    logic              wr_fire;
    logic              wr_store;
    logic              send_req;
    logic              out_fire;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        byte_rd;

    // Handshake and request decode
    assign out_fire   = valid_q & uart_data_ready;
    assign wr_fire    = wr_valid & wr_ready_q;
    assign wr_store   = wr_fire & ~is_eol(wr_data);
    assign send_req   = (state_q == ST_IDLE) & (send | (wr_fire & is_eol(wr_data)));
    assign rd_idx_inc = rd_idx_q + CNT_W'(1);

    // Read the byte that will be presented next: the following index when
    // the current payload byte is being accepted, otherwise the current one.
    assign rd_addr = (state_q == ST_DATA && out_fire) ? rd_idx_inc[AW-1:0]
                                                      : rd_idx_q[AW-1:0];

    // A byte written in the same cycle as send into an empty buffer lands at
    // index 0, which the buffer cannot return yet, so forward it directly.
    assign byte_rd = (state_q == ST_IDLE && wr_store && count_q == '0) ? wr_data : rd_data;

    uart_line_buf #(
        .DEPTH (CHARLEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_store),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        gap_d    = gap_q;
        data_d   = data_q;
        valid_d  = valid_q;
        after_st = ST_IDLE;
        tgt      = ST_IDLE;
        enter    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_store) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (send_req) begin
                    if (count_d != '0) begin
                        enter = 1'b1;
                        tgt   = ST_DATA;
                    end else if (AUTO_EOL != 0) begin
                        enter = 1'b1;
                        tgt   = ST_CR;
                    end
                end
            end

            ST_DATA, ST_CR, ST_LF: begin
                if (out_fire) begin
                    if (state_q == ST_DATA) begin
                        rd_idx_d = rd_idx_inc;
                        if (rd_idx_inc < count_q) begin
                            after_st = ST_DATA;
                        end else if (AUTO_EOL != 0) begin
                            after_st = ST_CR;
                        end else begin
                            after_st = ST_IDLE;
                        end
                    end else if (state_q == ST_CR) begin
                        after_st = ST_LF;
                    end else begin
                        after_st = ST_IDLE;
                    end

                    // Line fully delivered: drop it as soon as the last byte goes
                    if (after_st == ST_IDLE) begin
                        count_d  = '0;
                        rd_idx_d = '0;
                    end

                    if (GAP == 0) begin
                        enter = 1'b1;
                        tgt   = after_st;
                    end else begin
                        state_d = ST_GAP;
                        valid_d = 1'b0;
                        gap_d   = GW'(GAP - 1);
                        nxt_d   = after_st;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    enter = 1'b1;
                    tgt   = nxt_q;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Load the output register for the state being entered
        if (enter) begin
            state_d = tgt;
            case (tgt)
                ST_DATA: begin
                    data_d  = byte_rd;
                    valid_d = 1'b1;
                end
                ST_CR: begin
                    data_d  = CHAR_CR;
                    valid_d = 1'b1;
                end
                ST_LF: begin
                    data_d  = CHAR_LF;
                    valid_d = 1'b1;
                end
                default: begin
                    data_d  = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            nxt_q      <= ST_IDLE;
            count_q    <= '0;
            rd_idx_q   <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d != ST_IDLE);
            wr_ready_q <= (state_d == ST_IDLE) && (count_d < CNT_W'(CHARLEN));
        end
    end

    assign uart_data       = data_q;
    assign uart_data_valid = valid_q;
    assign busy            = busy_q;
    assign wr_ready        = wr_ready_q;
    assign count           = count_q;

endmodule

// File: tb/tb_uart_line_feed.sv
// Directed testbench for uart_line_feed: a per-cycle vector table for the
// basic line transfer plus hand-written multi-cycle corner cases.
module tb_uart_line_feed;
    import uart_sim_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       send;
    logic       uart_data_ready;

    logic       wr_ready,  wr_ready4;
    logic [7:0] uart_data, uart_data4;
    logic       valid,     valid4;
    logic       busy,      busy4;
    logic [8:0] count;
    logic [2:0] count4;

    int n_tests;
    int n_fail;

    logic [7:0] rxq[$];
    logic [7:0] rxq4[$];
    logic [7:0] expq[$];

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       snd;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       ewr;
        int         ecnt;
    } vec_t;

    vec_t tab[15];

    always #5 clk = ~clk;

    uart_line_feed #(.CHARLEN(256), .GAP(2), .AUTO_EOL(1)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .send            (send),
        .uart_data       (uart_data),
        .uart_data_valid (valid),
        .uart_data_ready (uart_data_ready),
        .busy            (busy),
        .count           (count)
    );

    uart_line_feed #(.CHARLEN(4), .GAP(2), .AUTO_EOL(1)) dut4 (
        .clk             (clk),
        .resetn          (resetn),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready4),
        .send            (send),
        .uart_data       (uart_data4),
        .uart_data_valid (valid4),
        .uart_data_ready (uart_data_ready),
        .busy            (busy4),
        .count           (count4)
    );

    // Record every byte the sink accepts
    always @(posedge clk) begin
        if (valid && uart_data_ready)  rxq.push_back(uart_data);
        if (valid4 && uart_data_ready) rxq4.push_back(uart_data4);
    end

    function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic snd,
                                input logic ev, input logic [7:0] ed, input logic eb,
                                input logic ewr, input int ecnt);
        vec_t v;
        v.wv = wv; v.wd = wd; v.snd = snd;
        v.ev = ev; v.ed = ed; v.eb = eb; v.ewr = ewr; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_valid        = 1'b0;
        wr_data         = 8'h00;
        send            = 1'b0;
        uart_data_ready = 1'b1;
        resetn          = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        rxq.delete();
        rxq4.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_send();
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit use4);
        int k = 0;
        while ((use4 ? busy4 : busy) && k < 200) begin
            tick();
            k++;
        end
        check(name, 32'(use4 ? busy4 : busy), 32'd0);
    endtask

    task automatic check_stream(input string name, input bit use4);
        logic [7:0] got[$];
        logic [31:0] act;
        if (use4) got = rxq4;
        else      got = rxq;
        check({name, "_len"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            act = (i < got.size()) ? 32'(got[i]) : 32'h100;
            check($sformatf("%s[%0d]", name, i), act, 32'(expq[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] act, exp;
        n_tests = 0;
        n_fail  = 0;

        // Reset state
        wr_valid = 1'b0; wr_data = 8'h00; send = 1'b0; uart_data_ready = 1'b1;
        resetn = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(uart_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        resetn = 1'b1;
        tick();
        check("rel_wr_ready", 32'(wr_ready), 32'd1);
        rxq.delete();
        rxq4.delete();

        // "hi" + send, ready high, GAP=2: per-cycle expectations
        //             wv    wd     snd   ev    ed     eb    ewr   cnt
        tab[0]  = mk(1'b1, 8'h68, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
        tab[1]  = mk(1'b1, 8'h69, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2);
        tab[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h68, 1'b1, 1'b0, 2);
        tab[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        tab[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        tab[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h69, 1'b1, 1'b0, 2);
        tab[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        tab[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        tab[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h0D, 1'b1, 1'b0, 2);
        tab[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        tab[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        tab[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 2);
        tab[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        tab[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        tab[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0);

        for (int i = 0; i < 15; i++) begin
            wr_valid = tab[i].wv;
            wr_data  = tab[i].wd;
            send     = tab[i].snd;
            tick();
            act = 32'({valid, (tab[i].ev ? uart_data : 8'h00), busy, wr_ready, count});
            exp = 32'({tab[i].ev, tab[i].ed, tab[i].eb, tab[i].ewr, 9'(tab[i].ecnt)});
            check($sformatf("hi_step%0d", i), act, exp);
        end
        wr_valid = 1'b0;
        send     = 1'b0;
        expq = '{8'h68, 8'h69, 8'h0D, 8'h0A};
        check_stream("hi_stream", 1'b0);

        // Written LF acts as send and is not stored
        do_reset();
        write_byte(8'h61);
        write_byte(8'h62);
        write_byte(8'h0A);
        check("lf_count",  32'(count), 32'd2);
        check("lf_busy",   32'(busy), 32'd1);
        check("lf_first",  32'(uart_data), 32'h61);
        wait_idle("lf_done", 1'b0);
        check("lf_count_end", 32'(count), 32'd0);
        expq = '{8'h61, 8'h62, 8'h0D, 8'h0A};
        check_stream("lf_stream", 1'b0);

        // Backpressure: first byte held for 10 cycles
        do_reset();
        uart_data_ready = 1'b0;
        write_byte(8'h61);
        write_byte(8'h62);
        pulse_send();
        check("bp_valid_0", 32'(valid), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), 32'({valid, uart_data}), 32'({1'b1, 8'h61}));
        end
        uart_data_ready = 1'b1;
        tick();
        check("bp_accept_cnt", 32'(rxq.size()), 32'd1);
        check("bp_valid_drop", 32'(valid), 32'd0);
        wait_idle("bp_done", 1'b0);
        expq = '{8'h61, 8'h62, 8'h0D, 8'h0A};
        check_stream("bp_stream", 1'b0);

        // CHARLEN=4: fifth write refused, four bytes sent
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h41 + i);
            tick();
            if (i == 3) begin
                check("cl4_wr_ready_full", 32'(wr_ready4), 32'd0);
                check("cl4_count_full",    32'(count4), 32'd4);
            end
        end
        wr_valid = 1'b0;
        check("cl4_count_after5", 32'(count4), 32'd4);
        pulse_send();
        wait_idle("cl4_done", 1'b1);
        expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        check_stream("cl4_stream", 1'b1);

        // Empty line, and a second send while busy
        do_reset();
        pulse_send();
        check("empty_first", 32'({valid, uart_data}), 32'({1'b1, 8'h0D}));
        check("empty_busy",  32'(busy), 32'd1);
        pulse_send();
        wait_idle("empty_done", 1'b0);
        repeat (6) tick();
        check("empty_busy_after", 32'(busy), 32'd0);
        expq = '{8'h0D, 8'h0A};
        check_stream("empty_stream", 1'b0);

        // Write and send in the same cycle include the byte
        do_reset();
        wr_valid = 1'b1;
        wr_data  = 8'h71;
        send     = 1'b1;
        tick();
        wr_valid = 1'b0;
        send     = 1'b0;
        check("ws_first", 32'({valid, uart_data}), 32'({1'b1, 8'h71}));
        wait_idle("ws_done", 1'b0);
        expq = '{8'h71, 8'h0D, 8'h0A};
        check_stream("ws_stream", 1'b0);

        // Reset while the second byte is presented
        do_reset();
        write_byte(8'h78);
        write_byte(8'h79);
        pulse_send();
        tick();
        tick();
        tick();
        check("mr_second", 32'({valid, uart_data}), 32'({1'b1, 8'h79}));
        resetn = 1'b0;
        #1;
        check("mr_valid", 32'(valid), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_busy",  32'(busy), 32'd0);
        check("mr_data",  32'(uart_data), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("mr_wr_ready", 32'(wr_ready), 32'd1);
        repeat (8) tick();
        check("mr_quiet_valid", 32'(valid), 32'd0);
        check("mr_quiet_rx",    32'(rxq.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_feed.md
UART_LINE_FEED -- requirements
Module: uart_line_feed

Interface
REQ-001 SHALL have parameter CHARLEN, default 256: line buffer depth in bytes.
REQ-002 SHALL have parameter GAP, default 2: idle cycles inserted after each accepted output byte.
REQ-003 SHALL have parameter AUTO_EOL, default 1: 1 = append 0x0D then 0x0A after the line payload.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port wr_data, input, 8: character to append to the line buffer.
REQ-007 SHALL have port wr_valid, input, 1: wr_data is valid this cycle.
REQ-008 SHALL have port wr_ready, output, 1: a character is accepted on any cycle where wr_valid and wr_ready are both high.
REQ-009 SHALL have port send, input, 1: single-cycle request to transmit the buffered line.
REQ-010 SHALL have port uart_data, output, 8: output byte, matching the 8-bit data/valid byte-stream format our UART monitors consume.
REQ-011 SHALL have port uart_data_valid, output, 1: uart_data is valid.
REQ-012 SHALL have port uart_data_ready, input, 1: the sink accepts the byte when valid and ready are both high.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port count, output, $clog2(CHARLEN)+1: number of bytes currently buffered.

Function
REQ-015 SHALL implement the states IDLE, DATA, CR, LF and GAP.
REQ-016 SHALL drive wr_ready = (state==IDLE) & (count<CHARLEN); no write is ever dropped silently.
REQ-017 SHALL, in IDLE, store an accepted byte other than 0x0D/0x0A at buf[count] and increment count.
REQ-018 SHALL treat an accepted 0x0D or 0x0A as a send request and SHALL NOT store it.
REQ-019 SHALL, on a send request in IDLE, go to DATA if count>0, otherwise to CR if AUTO_EOL=1, otherwise stay in IDLE.
REQ-020 SHALL, when send and an accepted ordinary write occur in the same cycle, store the byte first so the transmitted line includes it.
REQ-021 SHALL ignore send while busy.
REQ-022 SHALL present buf[rd_idx] in DATA, with rd_idx starting at 0, and the byte order on uart_data SHALL equal the write order.
REQ-023 SHALL, once uart_data_valid is high, hold uart_data stable and keep valid high until uart_data_ready is sampled high.
REQ-024 SHALL, after each accepted byte, enter GAP for exactly GAP cycles with valid low; if GAP=0, the next byte SHALL be presented on the next cycle.
REQ-025 SHALL, after GAP, return to DATA while rd_idx<count; when the payload is exhausted, go to CR if AUTO_EOL=1, else to IDLE.
REQ-026 SHALL present 0x0D in CR and then 0x0A in LF; each of these SHALL follow the rules of REQ-023 and REQ-024.
REQ-027 SHALL, after the LF byte is accepted, clear count and rd_idx and enter IDLE.
REQ-028 SHALL deliver a first byte in DATA no earlier than one cycle after send, so latency from send to the first valid is 1 cycle.
REQ-029 SHALL, when count reaches CHARLEN, deassert wr_ready; a send request then transmits all CHARLEN bytes, with index arithmetic that never wraps.

Reset
REQ-030 SHALL, on resetn low, immediately (asynchronously) force state=IDLE, count=0, rd_idx=0, uart_data_valid=0, uart_data=0x00 and busy=0.
REQ-031 SHALL, on reset mid-transmission, abandon the line with no further output, and SHALL NOT require buffer contents to be cleared.
REQ-032 SHALL assert wr_ready on the first clock edge after reset release.

Structure
REQ-033 SHALL take CHAR_CR (0x0D), CHAR_LF (0x0A) and the state enum type from the shared package uart_sim_pkg, which the UART print monitor also uses.
REQ-034 SHALL instantiate one sub-module, uart_line_buf: a CHARLEN x 8 single-write/single-read buffer with combinational read.
REQ-035 SHALL keep the FSM, gap counter and index counters in uart_line_feed.

Verification
REQ-036 SHALL verify: write "hi", pulse send, ready held high, GAP=2 -> bytes 0x68, 0x69, 0x0D, 0x0A, each valid 1 cycle with 2-cycle gaps, then busy=0 and count=0.
REQ-037 SHALL verify: write "ab" then write 0x0A -> same output as send ("ab\r\n"), with 0x0A not stored in the buffer.
REQ-038 SHALL verify: ready held low for 10 cycles on the first byte -> valid stays high and uart_data stays at 0x61 throughout; the byte is accepted in cycle 11.
REQ-039 SHALL verify: CHARLEN=4, write 5 bytes -> wr_ready=0 after the 4th byte, and send outputs exactly 4 bytes plus CR/LF.
REQ-040 SHALL verify: send with count=0 -> output 0x0D, 0x0A only; send pulsed again while busy -> ignored.
REQ-041 SHALL verify: resetn low while the 2nd byte is presented -> valid=0 in the same cycle, count=0, and wr_ready=1 after release.
